imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MEM_BYTES, default 421, sets the byte capacity of the target instruction memory (addresses 0..MEM_BYTES-1).
REQ-002 Parameter ADDR_W, default 32, sets the width of wr_addr.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle request to begin a load session.
REQ-006 in_valid  input  1  source presents a byte on in_data.
REQ-007 in_data  input  8  stream byte.
REQ-008 in_ready  output  1  loader can accept a byte this cycle.
REQ-009 wr_en  output  1  byte write strobe to instruction memory.
REQ-010 wr_addr  output  ADDR_W  byte address of the write.
REQ-011 wr_data  output  8  byte written at wr_addr.
REQ-012 busy  output  1  session in progress.
REQ-013 done  output  1  last session completed with a good checksum.
REQ-014 error  output  1  last session aborted (length overflow or checksum mismatch).
REQ-015 cpu_hold  output  1  keeps the processor stalled while memory contents are not valid.
REQ-016 byte_count  output  16  payload bytes written in the current or last session.

Function
REQ-017 A byte transfer shall occur in a cycle when in_valid and in_ready are both 1; in_data shall be ignored in all other cycles.
REQ-018 Stream format: length high byte, length low byte (payload length N, unsigned 16-bit big-endian), N payload bytes, one checksum byte.
REQ-019 Payload byte k (0-based) shall be written to address k, so a 32-bit word at address A is {A, A+1, A+2, A+3}, most significant byte at the lowest address.
REQ-020 States: IDLE, LEN_HI, LEN_LO, PAYLOAD, CHECK, DONE, ERR.
REQ-021 IDLE: start=1 shall move to LEN_HI, clear done, error and byte_count, and reset the checksum accumulator to 8'h00.
REQ-022 LEN_HI -> LEN_LO on transfer; the byte is stored as N[15:8].
REQ-023 LEN_LO on transfer: N > MEM_BYTES -> ERR; N = 0 -> CHECK; otherwise -> PAYLOAD.
REQ-024 PAYLOAD: each transfer shall XOR the byte into the checksum, increment byte_count, and move to CHECK on the N-th byte.
REQ-025 CHECK on transfer: byte equal to the accumulator -> DONE, otherwise -> ERR.
REQ-026 in_ready shall be 1 in LEN_HI, LEN_LO, PAYLOAD and CHECK, and 0 in IDLE, DONE and ERR.
REQ-027 The write path shall be registered with latency 1: a payload transfer in cycle t gives wr_en=1 in cycle t+1 with wr_addr=k and wr_data=that byte.
REQ-028 wr_en shall be 0 in every other cycle, including cycles that transfer length or checksum bytes.
REQ-029 busy shall be 1 exactly in LEN_HI, LEN_LO, PAYLOAD and CHECK.
REQ-030 done shall be 1 only in DONE; error shall be 1 only in ERR.
REQ-031 cpu_hold shall be 0 only in DONE.
REQ-032 start while busy=1 shall be ignored.
REQ-033 start in DONE or ERR shall behave as in IDLE (REQ-021) and shall raise cpu_hold again.
REQ-034 A final payload byte and start in the same cycle: the byte completes normally and start is ignored.
REQ-035 Bytes already written by an aborted session shall not be erased; cpu_hold stays 1 so the CPU does not execute them.
REQ-036 All state shall be flops; no combinational path shall run from in_valid to in_ready.

Reset
REQ-037 rst=1 at a rising edge, in any state, shall force IDLE with in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, byte_count=0, cpu_hold=1 and the checksum accumulator at 8'h00.
REQ-038 rst asserted mid-session shall abandon the session; any write registered in that cycle shall not be issued.
REQ-039 Memory contents are outside this block and are not affected by rst.

Verification
REQ-040 start, then stream 00 04 DE AD BE EF 22 with in_valid held high -> writes (0,DE)(1,AD)(2,BE)(3,EF) on consecutive cycles, each one cycle after its transfer; then done=1, cpu_hold=0, byte_count=4.
REQ-041 Same stream with checksum 23 -> all four writes still occur; then error=1, done=0, cpu_hold=1.
REQ-042 Length 01 A6 (422) with MEM_BYTES=421 -> ERR immediately after the second length byte; no wr_en pulses; in_ready=0 afterwards.
REQ-043 Length 00 00 followed by checksum 00 -> DONE with byte_count=0 and no writes.
REQ-044 in_valid toggled 1,0,1,0 during payload -> exactly one write per transfer and wr_addr increments without gaps.
REQ-045 rst pulsed after 2 of 4 payload bytes, then a full new session -> IDLE outputs per REQ-037, then a normal completion with addresses restarting at 0.

Source files
------------

// File: rtl/imem_loader_if.sv
// Stream-in / memory-write bus of the instruction memory loader.
// The master side supplies the byte stream and observes the write port.
// The slave side (the loader) accepts bytes and drives the byte writes.
interface imem_loader_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: receives a length-prefixed, XOR-checksummed
// byte stream and writes the payload bytes to consecutive addresses from 0.
// The CPU is held off until a session finishes with a matching checksum.
module imem_loader #(
    parameter int MEM_BYTES = 421,
    parameter int ADDR_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    imem_loader_if.slave     bus,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             cpu_hold,
    output logic [15:0]      byte_count
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        PAYLOAD,
        CHECK,
        DONE,
        ERR
    } state_t;

    // Capacity widened by one bit so a 16-bit length compares without sign issues.
    localparam logic [16:0] MEM_LIMIT = 17'(MEM_BYTES);

    state_t            state_reg, state_next;
    logic [15:0]       len_reg, len_next;
    logic [7:0]        csum_reg, csum_next;
    logic [15:0]       count_reg, count_next;
    logic              wr_en_reg, wr_en_next;
    logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
    logic [7:0]        wr_data_reg, wr_data_next;

    logic              session_active;
    logic              xfer;
    logic [15:0]       len_word;

    // Ready depends only on the registered state, never on in_valid.
    assign session_active = (state_reg == LEN_HI) || (state_reg == LEN_LO) ||
                            (state_reg == PAYLOAD) || (state_reg == CHECK);
    assign xfer           = bus.in_valid && session_active;
    assign len_word       = {len_reg[15:8], bus.in_data};

    assign bus.in_ready = session_active;
    assign bus.wr_en    = wr_en_reg;
    assign bus.wr_addr  = wr_addr_reg;
    assign bus.wr_data  = wr_data_reg;
    assign busy         = session_active;
    assign done         = (state_reg == DONE);
    assign error        = (state_reg == ERR);
    assign cpu_hold     = (state_reg != DONE);
    assign byte_count   = count_reg;

    // State and datapath registers; reset also cancels any pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            len_reg     <= 16'd0;
            csum_reg    <= 8'h00;
            count_reg   <= 16'd0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= 8'h00;
        end else begin
            state_reg   <= state_next;
            len_reg     <= len_next;
            csum_reg    <= csum_next;
            count_reg   <= count_next;
            wr_en_reg   <= wr_en_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
        end
    end

    // Next-state and datapath decode for the stream parser.
    always_comb begin
        state_next   = state_reg;
        len_next     = len_reg;
        csum_next    = csum_reg;
        count_next   = count_reg;
        wr_en_next   = 1'b0;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;

        case (state_reg)
            IDLE, DONE, ERR: begin
                // A new session may start from any non-busy state.
                if (start) begin
                    state_next = LEN_HI;
                    csum_next  = 8'h00;
                    count_next = 16'd0;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_next[15:8] = bus.in_data;
                    state_next     = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_next = len_word;
                    if ({1'b0, len_word} > MEM_LIMIT) begin
                        state_next = ERR;
                    end else if (len_word == 16'd0) begin
                        state_next = CHECK;
                    end else begin
                        state_next = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    csum_next    = csum_reg ^ bus.in_data;
                    count_next   = count_reg + 16'd1;
                    wr_en_next   = 1'b1;
                    wr_addr_next = ADDR_W'(count_reg);
                    wr_data_next = bus.in_data;
                    if (count_reg + 16'd1 == len_reg) begin
                        state_next = CHECK;
                    end
                end
            end
            CHECK: begin
                if (xfer) begin
                    state_next = (bus.in_data == csum_reg) ? DONE : ERR;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the driver pushes the expected write for
// every payload byte it hands over; a negedge monitor pops and compares each
// write the loader issues, including the cycle it appears in.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, error, cpu_hold;
    logic [15:0] byte_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    imem_loader_if #(.ADDR_W(32)) bus ();

    imem_loader #(.MEM_BYTES(421), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cpu_hold  (cpu_hold),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         bus.wr_addr, bus.wr_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wr_addr", bus.wr_addr, e.addr);
                check("wr_data", {24'd0, bus.wr_data}, {24'd0, e.data});
                check("wr_cycle", cyc, e.cyc);
                $display("write addr=%0d data=%02h cycle=%0d", bus.wr_addr, bus.wr_data, cyc);
            end
        end
    end

    // Offer one byte; returns at the negedge following its transfer edge.
    task automatic send_byte(input logic [7:0] b, input bit is_pay, input logic [31:0] exp_addr);
        bit   got = 1'b0;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus.in_ready === 1'b1) begin
                got = 1'b1;
                if (is_pay) begin
                    e.addr = exp_addr;
                    e.data = b;
                    e.cyc  = cyc + 1;
                    sb.push_back(e);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got in_ready=0 for byte %02h expected 1", b);
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1'b1);
        check("start_hold", cpu_hold, 1'b1);
        check("start_done", done, 1'b0);
        check("start_error", error, 1'b0);
        check("start_count", byte_count, 16'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1'b0);
        check({tag, "_wr_en"}, bus.wr_en, 1'b0);
        check({tag, "_wr_addr"}, bus.wr_addr, 32'd0);
        check({tag, "_wr_data"}, bus.wr_data, 8'h00);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_error"}, error, 1'b0);
        check({tag, "_count"}, byte_count, 16'd0);
        check({tag, "_hold"}, cpu_hold, 1'b1);
    endtask

    task automatic check_end(input string tag, input logic d, input logic e,
                             input logic h, input logic [15:0] n);
        check({tag, "_done"}, done, d);
        check({tag, "_error"}, error, e);
        check({tag, "_hold"}, cpu_hold, h);
        check({tag, "_count"}, byte_count, n);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_in_ready"}, bus.in_ready, 1'b0);
        check({tag, "_pending"}, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Good 4-byte session, start asserted alongside the last payload byte.
        pulse_start();
        send_byte(8'h00, 0, 0);
        send_byte(8'h04, 0, 0);
        send_byte(8'hDE, 1, 0);
        send_byte(8'hAD, 1, 1);
        send_byte(8'hBE, 1, 2);
        start = 1'b1;
        send_byte(8'hEF, 1, 3);
        start = 1'b0;
        send_byte(8'h22, 0, 0);
        idle(1);
        check_end("good", 1'b1, 1'b0, 1'b0, 16'd4);
        $display("session good: done=%0b error=%0b count=%0d", done, error, byte_count);

        // Same payload with wrong checksum; restart from DONE.
        pulse_start();
        send_byte(8'h00, 0, 0);
        send_byte(8'h04, 0, 0);
        send_byte(8'hDE, 1, 0);
        send_byte(8'hAD, 1, 1);
        send_byte(8'hBE, 1, 2);
        send_byte(8'hEF, 1, 3);
        send_byte(8'h23, 0, 0);
        idle(1);
        check_end("badsum", 1'b0, 1'b1, 1'b1, 16'd4);
        $display("session badsum: done=%0b error=%0b count=%0d", done, error, byte_count);

        // Length 422 exceeds capacity 421.
        pulse_start();
        send_byte(8'h01, 0, 0);
        send_byte(8'hA6, 0, 0);
        bus.in_valid = 1'b0;
        check_end("toolong", 1'b0, 1'b1, 1'b1, 16'd0);
        idle(3);
        check("toolong_ready_later", bus.in_ready, 1'b0);
        $display("session toolong: error=%0b in_ready=%0b", error, bus.in_ready);

        // Empty payload.
        pulse_start();
        send_byte(8'h00, 0, 0);
        send_byte(8'h00, 0, 0);
        send_byte(8'h00, 0, 0);
        idle(1);
        check_end("empty", 1'b1, 1'b0, 1'b0, 16'd0);
        $display("session empty: done=%0b count=%0d", done, byte_count);

        // Gapped in_valid during payload; checksum 11^22^33^44 = 44.
        pulse_start();
        send_byte(8'h00, 0, 0);
        send_byte(8'h04, 0, 0);
        send_byte(8'h11, 1, 0);
        idle(1);
        send_byte(8'h22, 1, 1);
        idle(1);
        send_byte(8'h33, 1, 2);
        idle(1);
        send_byte(8'h44, 1, 3);
        idle(1);
        send_byte(8'h44, 0, 0);
        idle(1);
        check_end("gapped", 1'b1, 1'b0, 1'b0, 16'd4);
        $display("session gapped: done=%0b count=%0d", done, byte_count);

        // Reset mid-session, coinciding with a third payload byte.
        pulse_start();
        send_byte(8'h00, 0, 0);
        send_byte(8'h04, 0, 0);
        send_byte(8'hAA, 1, 0);
        send_byte(8'hBB, 1, 1);
        bus.in_data = 8'hCC;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst_after");
        $display("mid-session reset: busy=%0b hold=%0b", busy, cpu_hold);

        // Fresh session restarts at address 0; checksum 01^02^04 = 07.
        pulse_start();
        send_byte(8'h00, 0, 0);
        send_byte(8'h03, 0, 0);
        send_byte(8'h01, 1, 0);
        send_byte(8'h02, 1, 1);
        send_byte(8'h04, 1, 2);
        send_byte(8'h07, 0, 0);
        idle(2);
        check_end("restart", 1'b1, 1'b0, 1'b0, 16'd3);
        $display("session restart: done=%0b count=%0d", done, byte_count);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
